regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Write-side front end for the 32x32 register file: merges the in-order pipeline writeback stream with out-of-order results from multi-cycle units (mul/div, loads) onto the register file's single write port (we/waddr/wdata). Aux results are buffered in a small FIFO behind a valid/ready handshake. A destination scoreboard tracks registers with outstanding multi-cycle results. A forwarding query covers the one-cycle gap before a registered write lands in the register file.

## Interface
- DEPTH, 2: aux FIFO entries (power of two, >=2)
- STARVE_LIMIT, 8: cycles a FIFO head may wait before the pipeline is stalled for one cycle
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pipe_we  in  1  pipeline writeback valid
- pipe_waddr  in  5  pipeline destination
- pipe_wdata  in  32  pipeline result
- aux_valid  in  1  multi-cycle result valid
- aux_ready  out  1  FIFO can accept
- aux_waddr  in  5  multi-cycle destination
- aux_wdata  in  32  multi-cycle result
- iss_valid  in  1  multi-cycle op issued; marks destination busy
- iss_addr  in  5  issued op destination
- busy  out  32  scoreboard, bit i = result for register i outstanding
- pipe_stall  out  1  pipeline must hold its writeback this cycle
- qaddr  in  5  forwarding query address
- qhit  out  1  pending write to qaddr on output register
- qdata  out  32  forwarded data
- we  out  1  register file write enable (registered)
- waddr  out  5  register file write address (registered)
- wdata  out  32  register file write data (registered)

## Operation
- Reset: we=0, waddr=0, wdata=0, busy=0, pipe_stall=0, FIFO emptied, starve counter=0; aux_ready=0 while rst=1. Reset mid-operation discards all buffered entries and clears busy.
- Push: aux_valid && aux_ready at edge, entry appended at FIFO tail. aux_ready = (count < DEPTH), from registered count only; a full FIFO does not accept even when a pop happens the same cycle.
- Output select per cycle, registered into we/waddr/wdata at the edge:
  - pipe_stall=1 and FIFO non-empty: pop head. Any pipe_we this cycle is dropped; upstream holds it by contract.
  - else pipe_we=1 and pipe_waddr!=0: pipeline write; FIFO untouched.
  - else FIFO non-empty: pop head.
  - else we<=0. waddr/wdata hold their previous values.
- Address 0: pipeline writes to r0 are ignored and do not occupy the port. Aux entries to r0 are accepted and queued. On pop they are discarded with we<=0 and busy untouched.
- Starve counter: counts cycles with FIFO non-empty and no pop. Reset to 0 on any pop or when the FIFO is empty. When the count reaches STARVE_LIMIT-1, pipe_stall<=1 for exactly the next cycle, then 0.
- Scoreboard:
  - iss_valid with iss_addr!=0 sets busy[iss_addr] at the edge.
  - Popping an aux entry with waddr!=0 clears busy[waddr] at the same edge.
  - Simultaneous set and clear of the same bit: set wins.
  - Pipeline writes never modify busy.
- Forwarding: qhit = we && waddr!=0 && waddr==qaddr; qdata = wdata (combinational). qaddr=0 always gives qhit=0.

## Timing
- Pipeline write presented in cycle N: we=1 in cycle N+1, committed to the register file at the end of cycle N+1. Read-visible from cycle N+2; covered by qhit in cycle N+1.
- Aux push at edge ending cycle N: entry is head in cycle N+1. With the pipe idle it is popped then and appears on we in cycle N+2.
- Throughput: one register file write per cycle max. FIFO push and pop may occur in the same cycle (count unchanged).
- Worst-case head wait with continuous pipe writes: STARVE_LIMIT cycles, then the stall cycle pops it.

## Test plan
- Reset: assert rst 2 cycles with aux_valid=1 -> we=0, busy=0, aux_ready=0, no push; after release aux_ready=1.
- Pipe write: pipe_we=1, waddr=5, wdata=0xDEADBEEF in cycle 1 -> cycle 2 we=1/waddr=5/wdata=0xDEADBEEF; qaddr=5 gives qhit=1, qdata=0xDEADBEEF. Same stimulus with waddr=0 -> we stays 0.
- Aux + scoreboard: iss r7 -> busy[7]=1. Push (7,0x1234) with pipe idle -> we=1/waddr=7 two cycles after push, busy[7]=0 the same cycle we rises.
- Priority/full: pipe_we=1 every cycle, push 2 aux entries -> aux_ready=0 after second push. Third aux_valid is held, not accepted. pipe_stall pulses after 8 waiting cycles, and the head is written in the stall cycle.
- Simultaneous: iss_valid r9 in same cycle as pop of aux entry to r9 -> busy[9]=1 afterward. Aux entry to r0 -> popped with we=0 and busy unchanged.
- Mid-op reset: FIFO holding 2 entries, busy[3]=1, rst pulsed 1 cycle -> FIFO empty, busy=0, no further aux writes appear.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter: merges pipeline writeback with buffered
// multi-cycle results, tracks outstanding destinations, and forwards the pending write.
module regfile_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  input  logic        aux_valid,
  output logic        aux_ready,
  input  logic [4:0]  aux_waddr,
  input  logic [31:0] aux_wdata,
  input  logic        iss_valid,
  input  logic [4:0]  iss_addr,
  output logic [31:0] busy,
  output logic        pipe_stall,
  input  logic [4:0]  qaddr,
  output logic        qhit,
  output logic [31:0] qdata,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT) + 1;

  logic [36:0]   mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          stall_q, stall_d;
  logic [31:0]   busy_q, busy_d;
  logic          we_q, we_d;
  logic [4:0]    waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic          empty, push, pop, pipe_take;
  logic [4:0]    head_addr;
  logic [31:0]   head_data;

  // Readiness comes from the registered count only, so a full FIFO never
  // accepts even if it pops in the same cycle.
  assign aux_ready = !rst && (count_q < CW'(DEPTH));
  assign push      = aux_valid && aux_ready;
  assign empty     = (count_q == '0);
  assign pipe_take = pipe_we && (pipe_waddr != 5'd0);
  assign pop       = !empty && (stall_q || !pipe_take);
  assign head_addr = mem_q[rd_ptr_q][36:32];
  assign head_data = mem_q[rd_ptr_q][31:0];

  always_comb begin
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    busy_d   = busy_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      if (head_addr != 5'd0) begin
        we_d              = 1'b1;
        waddr_d           = head_addr;
        wdata_d           = head_data;
        busy_d[head_addr] = 1'b0;
      end
    end else if (pipe_take) begin
      we_d    = 1'b1;
      waddr_d = pipe_waddr;
      wdata_d = pipe_wdata;
    end
    // Set after clear so a same-cycle reissue keeps the register busy.
    if (iss_valid && (iss_addr != 5'd0)) busy_d[iss_addr] = 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    count_d  = count_q + CW'(push) - CW'(pop);
    starve_d = (empty || pop) ? '0 : starve_q + SW'(1);
    stall_d  = !empty && !pop && (starve_q == SW'(STARVE_LIMIT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      busy_q   <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      busy_q   <= busy_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {aux_waddr, aux_wdata};
  end

  assign busy       = busy_q;
  assign pipe_stall = stall_q;
  assign we         = we_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign qhit       = we_q && (waddr_q != 5'd0) && (waddr_q == qaddr);
  assign qdata      = wdata_q;

endmodule
